// File: rtl/sd_adc_pkg.sv
// rtl/sd_adc_pkg.sv - shared constants, FSM states and helpers for the sigma-delta ADC
package sd_adc_pkg;

   localparam int NUM_CH        = 4;
   localparam int SETTLE_DECIMS = 3;
   localparam int MAX_ACC_W     = 25;   // widest filter path (OSR_LOG2 = 8)

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      SETTLE   = 2'd1,
      RUN      = 2'd2
   } adc_state_t;

   function automatic int acc_w(input int osr_log2);
      acc_w = 3 * osr_log2 + 1;
   endfunction

   // Full scale (2^(aw-1)) and above saturates; otherwise take the 16 bits
   // just below the sign position, zero-filling LSBs for narrow filters.
   function automatic logic [15:0] scale_out(input logic [MAX_ACC_W-1:0] r, input int aw);
      logic [MAX_ACC_W-1:0] full;
      full         = '0;
      full[aw-1]   = 1'b1;
      if (r >= full)
         scale_out = 16'hFFFF;
      else if (aw >= 17)
         scale_out = 16'(r >> (aw - 17));
      else
         scale_out = 16'(r << (17 - aw));
   endfunction

endpackage

// File: rtl/sinc3_channel.sv
// rtl/sinc3_channel.sv - one Sinc3 decimator: integrators, combs and output scaling
// Ports: clk, rst_n (async active-low), mod_tick (integrate), dec_tick (comb),
//        clr (hold all state at 0), sd_bit (bitstream), result[15:0] (scaled output)
module sinc3_channel
   import sd_adc_pkg::*;
#(
   parameter int OSR_LOG2 = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mod_tick,
   input  logic        dec_tick,
   input  logic        clr,
   input  logic        sd_bit,
   output logic [15:0] result
);

   localparam int ACC_W = acc_w(OSR_LOG2);

   logic [ACC_W-1:0]     i1, i2, i3;
   logic [ACC_W-1:0]     d1, d2, d3;
   logic [ACC_W-1:0]     c1, c2, c3;
   logic [ACC_W-1:0]     r;
   logic [MAX_ACC_W-1:0] r_ext;

   always_comb begin
      c1 = i3 - d1;
      c2 = c1 - d2;
      c3 = c2 - d3;
   end

   // dec_tick only coincides with mod_tick, so the combs see i3 before this
   // tick's integration step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i1 <= '0; i2 <= '0; i3 <= '0;
         d1 <= '0; d2 <= '0; d3 <= '0;
         r  <= '0;
      end else if (clr) begin
         i1 <= '0; i2 <= '0; i3 <= '0;
         d1 <= '0; d2 <= '0; d3 <= '0;
         r  <= '0;
      end else begin
         if (mod_tick) begin
            i1 <= i1 + ACC_W'(sd_bit);
            i2 <= i2 + i1;
            i3 <= i3 + i2;
         end
         if (dec_tick) begin
            d1 <= i3;
            d2 <= c1;
            d3 <= c2;
            r  <= c3;
         end
      end
   end

   always_comb begin
      r_ext            = '0;
      r_ext[ACC_W-1:0] = r;
      result           = scale_out(r_ext, ACC_W);
   end

endmodule

// File: rtl/sigma_delta_sinc3_adc.sv
// rtl/sigma_delta_sinc3_adc.sv - four-channel sigma-delta ADC back end with Sinc3 decimation
// Ports: clk, rst_n (async active-low), enable, sd_comp_in[3:0] (async comparators),
//        sd_fb_out[3:0] (feedback DAC bits), adc_ch0..3[15:0] (results),
//        adc_data_valid[3:0], adc_sample_cnt[31:0], data_read_strobe (clears flags)
module sigma_delta_sinc3_adc
   import sd_adc_pkg::*;
#(
   parameter int SD_CLK_DIV = 5,
   parameter int OSR_LOG2   = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [3:0]  sd_comp_in,
   output logic [3:0]  sd_fb_out,
   output logic [15:0] adc_ch0,
   output logic [15:0] adc_ch1,
   output logic [15:0] adc_ch2,
   output logic [15:0] adc_ch3,
   output logic [3:0]  adc_data_valid,
   output logic [31:0] adc_sample_cnt,
   input  logic        data_read_strobe
);

   logic [3:0]          sync1, sync2;
   logic [7:0]          div_cnt;
   logic [OSR_LOG2-1:0] dec_cnt;
   logic [1:0]          settle_cnt;
   logic                mod_tick, dec_tick, clr;
   logic                pub_pending, publish;
   adc_state_t          state, state_nxt;
   logic [15:0]         res [NUM_CH];

   assign clr      = (state == DISABLED);
   assign mod_tick = !clr && (div_cnt == 8'(SD_CLK_DIV - 1));
   assign dec_tick = mod_tick && (dec_cnt == '1);
   assign publish  = pub_pending && (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sd_comp_in;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt   <= '0;
         dec_cnt   <= '0;
         sd_fb_out <= '0;
      end else if (clr) begin
         div_cnt   <= '0;
         dec_cnt   <= '0;
         sd_fb_out <= '0;
      end else begin
         div_cnt <= mod_tick ? 8'd0 : div_cnt + 8'd1;
         if (mod_tick) begin
            dec_cnt   <= dec_cnt + OSR_LOG2'(1);
            sd_fb_out <= sync2;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= DISABLED;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!enable) begin
         state_nxt = DISABLED;
      end else begin
         case (state)
            DISABLED: state_nxt = SETTLE;
            SETTLE:   if (dec_tick && settle_cnt == 2'(SETTLE_DECIMS - 1)) state_nxt = RUN;
            RUN:      state_nxt = RUN;
            default:  state_nxt = DISABLED;
         endcase
      end
   end

   // Settling decimations are counted only while in SETTLE; the decimation
   // that completes settling is itself discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt  <= '0;
         pub_pending <= 1'b0;
      end else begin
         if (state != SETTLE)  settle_cnt <= '0;
         else if (dec_tick)    settle_cnt <= settle_cnt + 2'd1;
         pub_pending <= dec_tick && (state == RUN);
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sinc3_channel #(.OSR_LOG2(OSR_LOG2)) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .mod_tick (mod_tick),
         .dec_tick (dec_tick),
         .clr      (clr),
         .sd_bit   (sync2[i]),
         .result   (res[i])
      );
   end

   // A publish on the same cycle as a read strobe leaves the flags set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adc_ch0        <= '0;
         adc_ch1        <= '0;
         adc_ch2        <= '0;
         adc_ch3        <= '0;
         adc_data_valid <= '0;
         adc_sample_cnt <= '0;
      end else if (publish) begin
         adc_ch0        <= res[0];
         adc_ch1        <= res[1];
         adc_ch2        <= res[2];
         adc_ch3        <= res[3];
         adc_data_valid <= 4'hF;
         adc_sample_cnt <= adc_sample_cnt + 32'd1;
      end else if (data_read_strobe) begin
         adc_data_valid <= '0;
      end
   end

endmodule

// File: doc/sigma_delta_sinc3_adc.md
# sigma_delta_sinc3_adc

Four-channel sigma-delta ADC back end. It samples four external comparator bits at the modulator rate and drives the matching 1-bit feedback DACs. Each bitstream passes through a Sinc3 decimator, and the block publishes 16-bit results, per-channel valid flags and a sample counter. Its outputs feed the STM32 SPI slave's ADC inputs directly, and that slave's `data_read_strobe` clears the valid flags.

## Interface
Parameters:
- `SD_CLK_DIV`, 5: `clk` cycles per modulator tick, range 2..255 (50 MHz / 5 = 10 MHz).
- `OSR_LOG2`, 6: log2 of the decimation ratio, range 4..8 (OSR = 64). Internal width `ACC_W = 3*OSR_LOG2 + 1`.

Ports:
- `clk`, in, 1: system clock (50 MHz).
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: run/stop; low holds the filter in reset.
- `sd_comp_in`, in, 4: comparator outputs, asynchronous to `clk`.
- `sd_fb_out`, out, 4: feedback DAC bits (registered).
- `adc_ch0` … `adc_ch3`, out, 16 each: decimated results, unsigned.
- `adc_data_valid`, out, 4: per-channel new-sample flag.
- `adc_sample_cnt`, out, 32: published-sample counter.
- `data_read_strobe`, in, 1: one-cycle pulse from the SPI slave.

## Operation
- **Input synchronisation:** `sd_comp_in` passes through 2-FF synchronisers; the synchronised bit is `s[i]`.
- **Modulator tick:** a divider counts 0..SD_CLK_DIV-1 and asserts `mod_tick` for one cycle at the terminal count. On `mod_tick`, `sd_fb_out[i] <= s[i]`.
- **Integrators:** three cascaded integrators per channel, width ACC_W, wrap modulo 2^ACC_W (no saturation). They update only on `mod_tick`: `i1 += s`, `i2 += i1`, `i3 += i2`, all using pre-update values.
- **Decimation:** a counter advances on each `mod_tick` and wraps at OSR-1. `dec_tick` is asserted on the `mod_tick` where it wraps.
- **Combs:** on `dec_tick`, three comb stages run on `i3`, each with its own delay register, all ACC_W wide with wrap arithmetic. The result `r` is registered.
- **Output scaling:** `out = (r >= 2^(ACC_W-1)) ? 16'hFFFF : r[ACC_W-2 -: 16]` when ACC_W-1 ≥ 16; otherwise left-justify, zero-filling the LSBs. An all-ones input gives r = 2^(ACC_W-1), which saturates to `FFFF`.
- **FSM** (states `DISABLED`, `SETTLE`, `RUN`):
  - `DISABLED`: all integrators, combs, divider and decimation counter are held at 0 and `sd_fb_out` = 0. Goes to `SETTLE` when `enable`=1.
  - `SETTLE`: count `dec_tick`s. After the 3rd one, go to `RUN`. Settling results are not published.
  - `RUN`: every comb result is published.
  - `enable`=0 in any state → `DISABLED` on the next cycle. The published `adc_chN`, `adc_sample_cnt` and flags keep their values.
- **Publish** (RUN, one cycle after `dec_tick`): all four `adc_chN` load together, `adc_data_valid <= 4'hF`, and `adc_sample_cnt` increments, wrapping at 2^32-1 → 0.
- **Flag clear:** `data_read_strobe` clears all four flags. If it coincides with a publish cycle, the set wins.

## Timing
- Reset values: every output is 0, including `sd_fb_out`. FSM = `DISABLED`; all counters and filter state are 0.
- Comparator to `sd_fb_out`: 2 sync cycles plus wait for the next `mod_tick`, then 1 register.
- `dec_tick` cycle T: comb registers update at T+1, outputs and flags update at T+2.
- Output period: SD_CLK_DIV·2^OSR_LOG2 `clk` cycles (6.4 µs at the defaults).
- The first publish occurs on the 4th `dec_tick` after `enable` rises.
- Reset mid-operation: an immediate asynchronous return to all-zero state.

## Structure
- **Package `sd_adc_pkg`:**
  - `NUM_CH = 4`.
  - FSM state enum (`DISABLED`, `SETTLE`, `RUN`).
  - `SETTLE_DECIMS = 3`.
  - An `acc_w(osr_log2)` function.
  - The output-scaling function.
- **Sub-module `sinc3_channel`:**
  - Contains the integrators, combs and scaling for one bitstream.
  - Inputs: `mod_tick`, `dec_tick`, `clr`, `bit`. Output: `result[15:0]`.
  - Instantiated four times.
- **Top level:** synchronisers, divider, decimation counter, FSM, publish registers, flags and counter.

## Test plan
- **All-ones, defaults:** `sd_comp_in`=4'hF, `enable`=1 → first publish on the 4th `dec_tick`; all channels = 16'hFFFF; flags = F; `adc_sample_cnt`=1.
- **Per-channel patterns:** ch0 all zeros, ch1 alternating 1/0, ch2 1-in-4, ch3 all ones → steady state 0x0000, 0x8000, 0x4000, 0xFFFF.
- **Flag handshake:** pulse `data_read_strobe` mid-period → flags go to 0 next cycle. Pulse it on the exact publish cycle → flags stay F.
- **Disable/re-enable:** drop `enable` in `RUN` → outputs hold and the filter clears. Raise it again → 3 settling decimations, then the counter resumes from its held value + 1.
- **Counter wrap and mid-run reset:** preload `adc_sample_cnt` to FFFF_FFFF via force → next publish gives 0. Assert `rst_n`=0 mid-run → all outputs are 0 asynchronously.
- **Parameter sweep:** `SD_CLK_DIV`=2 with `OSR_LOG2`=4 (ACC_W=13, left-justified) → all-ones gives 16'hFFFF, half-duty gives 0x8000, period = 32 cycles.
